pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage RV32 pipeline. It sits beside the forwarding hazard unit and resolves the hazards that forwarding cannot cover: load-use dependencies, taken branches and jumps, instruction-fetch wait states, data-memory wait states and the multi-cycle multiply/divide unit. It drives the enable and clear inputs of every pipeline register from a small registered state machine.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl_stall_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the state enum used by pipeline_ctrl and the default register-address width.
package pipe_pkg;

    // Default register-address width (32 architectural registers).
    localparam int DEF_ADDR_WIDTH = 5;

    // Sequencer states: normal flow, waiting on mul/div, waiting on data memory.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        DM_WAIT = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-information and pipeline-control bundle between the datapath and pipeline_ctrl.
// master: the datapath side (drives hazard info, receives stall/flush controls).
// slave:  the sequencer side (pipeline_ctrl).
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = pipe_pkg::DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] rs1D_i;
    logic [ADDR_WIDTH-1:0] rs2D_i;
    logic [ADDR_WIDTH-1:0] rdE_i;
    logic                  mem_readE_i;
    logic                  pc_srcE_i;
    logic                  muldivE_i;
    logic                  muldiv_done_i;
    logic                  muldiv_go_o;
    logic                  imem_ready_i;
    logic                  dmem_reqM_i;
    logic                  dmem_ready_i;
    logic                  stallF_o;
    logic                  stallD_o;
    logic                  stallE_o;
    logic                  stallM_o;
    logic                  flushD_o;
    logic                  flushE_o;
    logic                  flushM_o;
    logic                  flushW_o;

    modport master (
        output rs1D_i, rs2D_i, rdE_i, mem_readE_i, pc_srcE_i, muldivE_i,
               muldiv_done_i, imem_ready_i, dmem_reqM_i, dmem_ready_i,
        input  muldiv_go_o, stallF_o, stallD_o, stallE_o, stallM_o,
               flushD_o, flushE_o, flushM_o, flushW_o
    );

    modport slave (
        input  rs1D_i, rs2D_i, rdE_i, mem_readE_i, pc_srcE_i, muldivE_i,
               muldiv_done_i, imem_ready_i, dmem_reqM_i, dmem_ready_i,
        output muldiv_go_o, stallF_o, stallD_o, stallE_o, stallM_o,
               flushD_o, flushE_o, flushM_o, flushW_o
    );
endinterface

// File: rtl/pipeline_ctrl_stall_counter.sv
// Saturating up-counter: counts cycles with en_i high, sticks at all-ones,
// cleared only by reset.
module stall_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_reg;

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (en_i && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline. Resolves load-use, taken
// branch, fetch wait, data-memory wait and multi-cycle mul/div hazards.
// Optional macro PIPE_PERF_EN adds stall_cnt_o, a saturating count of stallF cycles.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipeline_ctrl_if.slave       bus
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);
    pipe_state_t           state_reg;
    pipe_state_t           state_next;
    logic [ADDR_WIDTH-1:0] rd_e;
    logic                  dm_miss;
    logic                  dm_wait;
    logic                  md_stall;
    logic                  load_use;

    assign rd_e = bus.rdE_i;

    // State register; reset aborts any pending wait immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, hazard detection and prioritised stall/flush decode.
    always_comb begin
        state_next   = state_reg;
        bus.stallF_o = 1'b0;
        bus.stallD_o = 1'b0;
        bus.stallE_o = 1'b0;
        bus.stallM_o = 1'b0;
        bus.flushD_o = 1'b0;
        bus.flushE_o = 1'b0;
        bus.flushM_o = 1'b0;
        bus.flushW_o = 1'b0;

        dm_miss  = bus.dmem_reqM_i & ~bus.dmem_ready_i;
        dm_wait  = ((state_reg == RUN) & dm_miss) |
                   ((state_reg == DM_WAIT) & ~bus.dmem_ready_i);
        // A done pulse in MD_BUSY releases the stall in the same cycle.
        md_stall = ((state_reg == RUN) & bus.muldivE_i) |
                   ((state_reg == MD_BUSY) & ~bus.muldiv_done_i);
        load_use = bus.mem_readE_i & (rd_e != '0) &
                   ((rd_e == bus.rs1D_i) | (rd_e == bus.rs2D_i));

        // Memory wait wins over a mul/div launch, so go only fires when no miss is pending.
        bus.muldiv_go_o = (state_reg == RUN) & ~dm_miss & bus.muldivE_i;

        unique case (state_reg)
            RUN: begin
                if (dm_miss) begin
                    state_next = DM_WAIT;
                end else if (bus.muldivE_i) begin
                    state_next = MD_BUSY;
                end
            end
            MD_BUSY: if (bus.muldiv_done_i) state_next = RUN;
            DM_WAIT: if (bus.dmem_ready_i) state_next = RUN;
            default: state_next = RUN;
        endcase

        if (dm_wait) begin
            // Freeze everything up to memory; retire a bubble into writeback.
            bus.stallF_o = 1'b1;
            bus.stallD_o = 1'b1;
            bus.stallE_o = 1'b1;
            bus.stallM_o = 1'b1;
            bus.flushW_o = 1'b1;
        end else if (md_stall) begin
            bus.stallF_o = 1'b1;
            bus.stallD_o = 1'b1;
            bus.stallE_o = 1'b1;
            bus.flushM_o = 1'b1;
        end else if (bus.pc_srcE_i) begin
            // PC must advance to the target, so no front-end stall here.
            bus.flushD_o = 1'b1;
            bus.flushE_o = 1'b1;
        end else if (load_use) begin
            bus.stallF_o = 1'b1;
            bus.stallD_o = 1'b1;
            bus.flushE_o = 1'b1;
        end else if (!bus.imem_ready_i) begin
            bus.stallF_o = 1'b1;
            bus.flushD_o = 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    stall_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (bus.stallF_o),
        .count_o (stall_cnt_o)
    );
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued when
// inputs are driven and checked at the following falling edge.
// Vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, muldiv_go}.
module tb_pipeline_ctrl;
    import pipe_pkg::*;

    localparam logic [8:0] NONE  = 9'b0000_0000_0;
    localparam logic [8:0] LU    = 9'b1100_0100_0;
    localparam logic [8:0] BR    = 9'b0000_1100_0;
    localparam logic [8:0] MDGO  = 9'b1110_0010_1;
    localparam logic [8:0] MD    = 9'b1110_0010_0;
    localparam logic [8:0] DM    = 9'b1111_0001_0;
    localparam logic [8:0] FW    = 9'b1000_1000_0;

    logic clk;
    logic rst_ni;
    int   n_assert;
    int   n_fail;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    pipeline_ctrl_if #(.ADDR_WIDTH(5)) bus ();

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt;
    logic [2:0]  stall_cnt3;
    logic [31:0] cnt_model;
    logic [2:0]  cnt3_model;

    pipeline_ctrl_if #(.ADDR_WIDTH(5)) bus3 ();
    assign bus3.rs1D_i        = bus.rs1D_i;
    assign bus3.rs2D_i        = bus.rs2D_i;
    assign bus3.rdE_i         = bus.rdE_i;
    assign bus3.mem_readE_i   = bus.mem_readE_i;
    assign bus3.pc_srcE_i     = bus.pc_srcE_i;
    assign bus3.muldivE_i     = bus.muldivE_i;
    assign bus3.muldiv_done_i = bus.muldiv_done_i;
    assign bus3.imem_ready_i  = bus.imem_ready_i;
    assign bus3.dmem_reqM_i   = bus.dmem_reqM_i;
    assign bus3.dmem_ready_i  = bus.dmem_ready_i;

    pipeline_ctrl #(.ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .stall_cnt_o(stall_cnt)
    );
    pipeline_ctrl #(.ADDR_WIDTH(5), .CNT_WIDTH(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus3), .stall_cnt_o(stall_cnt3)
    );
`else
    pipeline_ctrl #(.ADDR_WIDTH(5)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every hazard input at once.
    task automatic set_in(input logic mem_read, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic pc_src, input logic muldiv,
                          input logic done, input logic imem_rdy, input logic dreq,
                          input logic drdy);
        bus.mem_readE_i   = mem_read;
        bus.rdE_i         = rd;
        bus.rs1D_i        = rs1;
        bus.rs2D_i        = rs2;
        bus.pc_srcE_i     = pc_src;
        bus.muldivE_i     = muldiv;
        bus.muldiv_done_i = done;
        bus.imem_ready_i  = imem_rdy;
        bus.dmem_reqM_i   = dreq;
        bus.dmem_ready_i  = drdy;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Pop one expectation and compare it with the live outputs.
    task automatic check();
        logic [8:0] e;
        logic [8:0] o;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {bus.stallF_o, bus.stallD_o, bus.stallE_o, bus.stallM_o,
             bus.flushD_o, bus.flushE_o, bus.flushM_o, bus.flushW_o, bus.muldiv_go_o};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
        $display("step %-10s ctrl=%b exp=%b", t, o, e);
`ifdef PIPE_PERF_EN
        if (!rst_ni) begin
            cnt_model  = '0;
            cnt3_model = '0;
        end
        n_assert++;
        assert (stall_cnt === cnt_model) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed %0d expected %0d", t, stall_cnt, cnt_model);
        end
        n_assert++;
        assert (stall_cnt3 === cnt3_model) else begin
            n_fail++;
            $error("FAIL %s_cnt3: observed %0d expected %0d", t, stall_cnt3, cnt3_model);
        end
        if (rst_ni && e[8]) begin
            if (cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 1;
            if (cnt3_model != 3'd7) cnt3_model = cnt3_model + 1;
        end
`endif
    endtask

    // One clock cycle with the currently driven inputs and a queued expectation.
    task automatic step(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
`ifdef PIPE_PERF_EN
        cnt_model  = '0;
        cnt3_model = '0;
`endif
        rst_ni = 1'b0;
        idle();
        step("reset", NONE);
        rst_ni = 1'b1;
        step("idle", NONE);

        // Load-use on rs2, held for one cycle only.
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_rs2", LU);
        idle();
        step("lu_clear", NONE);
        set_in(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_rs1", LU);
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_x0", NONE);
        set_in(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_noload", NONE);
        set_in(1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_nomatch", NONE);

        // Branch overriding load-use and fetch wait.
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("br_lu", BR);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("fetch", FW);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("br_fetch", BR);
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_fetch", LU);

        // Multi-cycle op: go once, 32 busy cycles, done after 33 cycles.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("md_go", MDGO);
        for (int i = 1; i < 33; i++) begin
            bus.pc_srcE_i = (i == 16);
            step((i == 16) ? "md_br" : "md_busy", MD);
        end
        bus.pc_srcE_i     = 1'b0;
        bus.muldiv_done_i = 1'b1;
        step("md_done", NONE);
        idle();
        step("md_after", NONE);

        // Data-memory wait for three cycles, then released.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("dm_wait", DM);
        bus.dmem_ready_i = 1'b1;
        step("dm_ready", NONE);
        idle();
        step("dm_after", NONE);

        // Memory miss beats a mul/div launch; done and ready together.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("dm_md", DM);
        step("dm_md_hold", DM);
        bus.dmem_ready_i  = 1'b1;
        bus.muldiv_done_i = 1'b1;
        step("dm_md_rdy", NONE);
        bus.dmem_reqM_i   = 1'b0;
        bus.dmem_ready_i  = 1'b0;
        bus.muldiv_done_i = 1'b0;
        step("md_relaunch", MDGO);
        bus.muldiv_done_i = 1'b1;
        step("md_fastdone", NONE);
        idle();
        step("md_idle", NONE);

        // Reset in the middle of a divide, then a stray done pulse.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("div_go", MDGO);
        for (int i = 1; i < 10; i++) step("div_busy", MD);
        idle();
        rst_ni = 1'b0;
        step("div_rst", NONE);
        rst_ni = 1'b1;
        bus.muldiv_done_i = 1'b1;
        step("stray_done", NONE);
        idle();
        step("post_rst", NONE);

        // Stall-count scenario: four load-use stalls, a three-cycle miss, two fetch waits.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step("cnt_lu", LU);
            idle();
            step("cnt_idle", NONE);
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("cnt_dm", DM);
        bus.dmem_ready_i = 1'b1;
        step("cnt_dm_rdy", NONE);
        idle();
        step("cnt_seven", NONE);
        bus.imem_ready_i = 1'b0;
        step("cnt_fw1", FW);
        step("cnt_fw2", FW);
        idle();
        step("cnt_nine", NONE);
        step("cnt_final", NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
